// File: rtl/holy_lsu.sv
// holy_lsu: load/store responder driving a word-addressed, byte-strobed request/grant/response bus.
// Optional bus-timeout fault is enabled by defining LSU_TIMEOUT_EN.
module holy_lsu #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              stall,
    output logic              fault,
    output logic [1:0]        fault_cause,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t     state, state_next;
    logic [2:0] func3_q;
    logic [1:0] off_q;
    logic       accept;
    logic       load_fire;
    logic       size_bad;
    logic       misaligned;
    logic       timeout_hit;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd4:    return {24'b0, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd5:    return {16'b0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
    assign size_bad = req_read ? !(func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                               : !(func3 inside {3'd0, 3'd1, 3'd2});
    assign misaligned = ((func3[1:0] == 2'd1) && addr[0]) ||
                        ((func3[1:0] == 2'd2) && (addr[1:0] != 2'b00));

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if (accept)
            tcnt <= '0;
        else if (state == S_REQ || state == S_WAIT)
            tcnt <= tcnt + 1'b1;
    end

    // Fires on the last permitted REQ/WAIT cycle when the awaited handshake is still missing.
    assign timeout_hit = (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                         ((state == S_REQ && !mem_gnt) || (state == S_WAIT && !mem_rvalid));
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next  = state;
        stall       = 1'b0;
        fault       = 1'b0;
        fault_cause = 2'b00;
        mem_req     = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        load_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_read || req_write) begin
                    if ((req_read && req_write) || size_bad) begin
                        fault       = 1'b1;
                        fault_cause = 2'b10;
                    end else if (misaligned) begin
                        fault       = 1'b1;
                        fault_cause = 2'b01;
                    end else begin
                        stall      = 1'b1;
                        accept     = 1'b1;
                        state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (timeout_hit) begin
                    fault       = 1'b1;
                    fault_cause = 2'b11;
                    state_next  = S_IDLE;
                end else begin
                    mem_req = 1'b1;
                    stall   = 1'b1;
                    if (mem_gnt) begin
                        if (mem_we || mem_rvalid) state_next = S_DONE;
                        else                      state_next = S_WAIT;
                        load_fire = !mem_we && mem_rvalid;
                    end
                end
            end
            S_WAIT: begin
                if (timeout_hit) begin
                    fault       = 1'b1;
                    fault_cause = 2'b11;
                    state_next  = S_IDLE;
                end else begin
                    stall = 1'b1;
                    if (mem_rvalid) begin
                        load_fire  = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= S_IDLE;
            func3_q   <= 3'd0;
            off_q     <= 2'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
            rdata     <= 32'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                func3_q  <= func3;
                off_q    <= addr[1:0];
                mem_we   <= req_write;
                mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                if (req_write) begin
                    case (func3[1:0])
                        2'd0: begin
                            mem_wdata <= {4{wdata[7:0]}};
                            mem_wstrb <= 4'b0001 << addr[1:0];
                        end
                        2'd1: begin
                            mem_wdata <= {2{wdata[15:0]}};
                            mem_wstrb <= 4'b0011 << addr[1:0];
                        end
                        default: begin
                            mem_wdata <= wdata;
                            mem_wstrb <= 4'b1111;
                        end
                    endcase
                end else begin
                    mem_wdata <= 32'd0;
                    mem_wstrb <= 4'd0;
                end
            end
            if (load_fire)
                rdata <= extract(mem_rdata, off_q, func3_q);
        end
    end

endmodule

// File: doc/holy_lsu.md
Name: holy_lsu

Overview:
- Load/store responder. Executes the `mem_read` / `mem_write` requests that the control unit raises for load (opcode 0000011) and store (opcode 0100011) instructions.
- Drives a word-addressed, byte-strobed data-memory request/grant/response bus.
- Handles byte, halfword and word sizing, store lane steering and load sign/zero extension.
- Stalls the core until the access completes, and reports misalignment, illegal size and bus faults.

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in REQ+WAIT before a bus fault. Used only with `LSU_TIMEOUT_EN`. Must be ≥1.
- `ADDR_W`, default 32: address width.

Ports:
- `clk` in 1: clock
- `rst_n` in 1: asynchronous active-low reset
- `req_read` in 1: load request (control `mem_read`)
- `req_write` in 1: store request (control `mem_write`)
- `func3` in 3: access size/sign (0 B, 1 H, 2 W, 4 BU, 5 HU)
- `addr` in `ADDR_W`: effective byte address (ALU result)
- `wdata` in 32: store data (rs2)
- `rdata` out 32: extended load result, valid while `done`=1
- `done` out 1: one-cycle completion pulse
- `stall` out 1: core must hold PC and pipeline inputs
- `fault` out 1: one-cycle fault pulse
- `fault_cause` out 2: 01 misaligned, 10 illegal size/conflict, 11 bus timeout; valid with `fault`
- `mem_req` out 1: bus request
- `mem_we` out 1: 1 write, 0 read
- `mem_addr` out `ADDR_W`: word-aligned address `{addr[ADDR_W-1:2],2'b00}`
- `mem_wdata` out 32: lane-steered store data
- `mem_wstrb` out 4: byte strobes (0 on reads)
- `mem_gnt` in 1: request accepted
- `mem_rvalid` in 1: read data valid
- `mem_rdata` in 32: read word

Behaviour:
- Reset (async, `rst_n`=0):
  - state=IDLE; timeout counter cleared.
  - All outputs 0: `rdata`, `done`, `stall`, `fault`, `fault_cause`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`.
  - Reset mid-access drops `mem_req` immediately; any later `mem_gnt`/`mem_rvalid` for the aborted access is ignored.
- Requester contract: `req_*`, `func3`, `addr` and `wdata` are held stable while `stall`=1.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, request seen (`req_read | req_write`):
  - Checks, in priority order:
    - both `req_read` and `req_write` set → cause 10
    - illegal `func3` → cause 10. Loads accept only 0,1,2,4,5; stores accept only 0,1,2.
    - misaligned (H with `addr[0]`=1, W with `addr[1:0]`≠0) → cause 01
  - On any error: `fault`=1 combinationally this cycle, no bus access, `stall`=0, stay IDLE.
  - Otherwise: `stall`=1 combinationally; register `mem_addr`, `mem_we`, `mem_wstrb`, `mem_wdata`, `func3` and the byte offset; go to REQ.
- REQ:
  - `mem_req`=1, `stall`=1.
  - On `mem_gnt`: a store goes to DONE.
  - On `mem_gnt` for a load: if `mem_rvalid` is also high this cycle, capture the data and go to DONE; otherwise go to WAIT.
  - `mem_req` deasserts the cycle after the grant.
- WAIT: `stall`=1, `mem_req`=0; on `mem_rvalid`, capture the extended `rdata` and go to DONE.
- DONE: `done`=1, `stall`=0, `rdata` presented; go to IDLE unconditionally. Requests are not sampled in DONE; the core advances at the end of this cycle.
- Minimum latency:
  - store: 2 cycles of `stall` plus DONE
  - load with same-cycle `mem_gnt` and `mem_rvalid`: same as a store
  - load otherwise: +1 cycle per wait cycle
- Store steering, with `off` = `addr[1:0]`:
  - SB: `mem_wdata` = `{4{wdata[7:0]}}`, `mem_wstrb` = `4'b0001 << off`
  - SH: `mem_wdata` = `{2{wdata[15:0]}}`, `mem_wstrb` = `4'b0011 << off`
  - SW: `mem_wdata` = `wdata`, `mem_wstrb` = `4'b1111`
- Load extraction:
  - `sh` = `mem_rdata >> (8*off)`
  - LB sign-extends `sh[7]`; LBU zero-extends `sh[7:0]`
  - LH sign-extends `sh[15]`; LHU zero-extends `sh[15:0]`
  - LW passes `mem_rdata` unchanged
- `rdata` holds its last value outside DONE.
- `mem_rvalid` outside REQ/WAIT and `mem_gnt` outside REQ are ignored.

Optional Feature:
- `LSU_TIMEOUT_EN` defined:
  - A counter runs while in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES` without the awaited `mem_gnt`/`mem_rvalid`, the FSM returns to IDLE.
  - That cycle: `fault`=1, `fault_cause`=11, `stall`=0, `mem_req`=0; no `done` pulse.
  - The counter clears on entry to REQ.
- Undefined: no counter; the FSM waits indefinitely and fault cause 11 never occurs.

Test Plan:
- SB `addr`=0x1002, `wdata`=0xAABBCCDD, `mem_gnt` on the first REQ cycle → `mem_addr`=0x1000, `mem_wstrb`=0100, `mem_wdata`=0xDDDDDDDD, `mem_we`=1; `done` on cycle 3; `stall` high for 2 cycles.
- LB `addr`=0x2003, `mem_rdata`=0x80FF1234, `mem_rvalid` 2 cycles after `mem_gnt` → `rdata`=0xFFFFFF80; LBU with the same data → 0x00000080; `stall` held through WAIT.
- LH `addr`=0x3001 → `fault`=1, `fault_cause`=01 in the same cycle, `mem_req` never asserted, `stall`=0; a load with `func3`=3 → `fault_cause`=10.
- `req_read` and `req_write` both set → `fault_cause`=10; then an LW with `mem_gnt` and `mem_rvalid` in the same cycle → `done` on cycle 3, `rdata`=`mem_rdata`.
- `rst_n` pulsed low while in WAIT → `mem_req`, `stall` and `done` all 0 immediately; a late `mem_rvalid` is ignored; the next SW completes normally.
- With `LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, `mem_gnt` held 0 → `fault`=1, `fault_cause`=11 after 4 REQ cycles; no `done` pulse; FSM back in IDLE.
